// File: rtl/mem_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam logic [3:0] BE_WORD         = 4'b1111;
  localparam int         MEM_LAT_DEFAULT = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signals of the single-port memory arbiter.
interface mem_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic        dm_byte;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        stall_f;
  logic        stall_m;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_byte, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output stall_f, stall_m
  );

  // Pipeline plus memory view
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_byte, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  stall_f, stall_m
  );

endinterface

// File: rtl/mem_bytelane.sv
// Data-path byte handling: store replication and byte enables, load lane select with sign extension.
module mem_bytelane
  import mem_pkg::*;
(
  input  logic        st_byte,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  input  logic        ld_byte,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] st_word,
  output logic [31:0] ld_data
);

  function automatic logic signed [31:0] sext8(input logic signed [7:0] b);
    return 32'(b);
  endfunction

  logic [7:0] ld_sel;

  always_comb begin
    be      = BE_WORD;
    st_word = st_data;
    if (st_byte) begin
      be      = 4'b0001 << st_lane;
      st_word = {4{st_data[7:0]}};
    end
  end

  always_comb begin
    ld_sel = ld_word[7:0];
    unique case (ld_lane)
      2'd0: ld_sel = ld_word[7:0];
      2'd1: ld_sel = ld_word[15:8];
      2'd2: ld_sel = ld_word[23:16];
      2'd3: ld_sel = ld_word[31:24];
      default: ld_sel = ld_word[7:0];
    endcase
  end

  assign ld_data = ld_byte ? sext8(ld_sel) : ld_word;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency unified memory between fetch and the memory stage,
// data side first, with one-cycle acks and combinational pipeline stalls.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic    clk,
  input  logic    reset,
  mem_arbiter_if.slave bus
);

  localparam int                CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             grant_d;
  logic             grant_i;
  logic             done;

  logic             ld_byte;
  logic [1:0]       ld_lane;
  logic [3:0]       dm_be;
  logic [31:0]      dm_st_word;
  logic [31:0]      dm_ld_data;

  // Store path uses the live request; load path uses the lane latched at grant
  mem_bytelane u_bytelane (
    .st_byte (bus.dm_byte),
    .st_lane (bus.dm_addr[1:0]),
    .st_data (bus.dm_wdata),
    .ld_byte (ld_byte),
    .ld_lane (ld_lane),
    .ld_word (bus.mem_rdata),
    .be      (dm_be),
    .st_word (dm_st_word),
    .ld_data (dm_ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A side whose ack is high this cycle is masked so continuous demand alternates
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.dm_req && !bus.dm_ack) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (bus.if_req && !bus.if_ack) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt == CNT_LAST) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  cnt <= '0;
    else if (grant_d || grant_i) cnt <= CNT_INIT;
    else if (state != IDLE)     cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      ld_byte       <= 1'b0;
      ld_lane       <= '0;
    end else if (grant_d) begin
      bus.mem_addr  <= bus.dm_addr;
      bus.mem_we    <= bus.dm_we;
      bus.mem_be    <= dm_be;
      bus.mem_wdata <= dm_st_word;
      ld_byte       <= bus.dm_byte;
      ld_lane       <= bus.dm_addr[1:0];
    end else if (grant_i) begin
      bus.mem_addr  <= bus.if_addr;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= BE_WORD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.if_ack   <= 1'b0;
      bus.dm_ack   <= 1'b0;
      bus.if_rdata <= '0;
      bus.dm_rdata <= '0;
    end else begin
      bus.if_ack <= done && (state == BUSY_I);
      bus.dm_ack <= done && (state == BUSY_D);
      if (done && (state == BUSY_I)) bus.if_rdata <= bus.mem_rdata;
      if (done && (state == BUSY_D)) bus.dm_rdata <= dm_ld_data;
    end
  end

  assign bus.mem_en  = (state != IDLE);
  assign bus.stall_f = bus.if_req & ~bus.if_ack;
  assign bus.stall_m = bus.dm_req & ~bus.dm_ack;

endmodule
